// File: rtl/prl_hard_reset_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : prl_hard_reset_ctrl_if
// Description : PHY-side handshake between the hard/cable reset controller
//               and the PHY. The controller is the master: it raises PHY_req
//               and presents the reset type. The PHY answers with PHY_ACK.
// Revision    : 1.0 - initial release
// ============================================================================
interface prl_hard_reset_ctrl_if;
  logic       PHY_req;
  logic [2:0] PHY_req_type;
  logic       PHY_ACK;

  modport master (
    output PHY_req,
    output PHY_req_type,
    input  PHY_ACK
  );

  modport slave (
    input  PHY_req,
    input  PHY_req_type,
    output PHY_ACK
  );
endinterface
`default_nettype wire

// File: rtl/prl_hard_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prl_hard_reset_ctrl
// Description : USB-PD protocol-layer Hard Reset / Cable Reset transmitter.
//               Accepts a reset request from the TCPC TRANSMIT register,
//               drives a request/ack handshake towards the PHY with a
//               per-attempt timeout and bounded retries, then reports the
//               outcome through sticky write-1-to-clear ALERT bits.
//               Optional feature macro: PRL_HR_CABLE_RESET_EN
//                 defined   : TRANSMIT code 110 (cable reset) is accepted
//                 undefined : code 110 is rejected with ALERT[5]
// Revision    : 1.0 - initial release
// ============================================================================
module prl_hard_reset_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16,
  parameter int N_RETRY        = 2
) (
  input  wire logic                  CLK,
  input  wire logic                  reset,
  input  wire logic [7:0]            ioTRANSMIT,
  input  wire logic                  tx_strobe,
  input  wire logic [15:0]           alert_clr,
  prl_hard_reset_ctrl_if.master      phy,
  output logic      [7:0]            oTRANSMIT,
  output logic      [15:0]           ALERT,
  output logic      [7:0]            oRECEIVE_DETECT,
  output logic      [7:0]            oRECEIVE_BYTE_COUNT,
  output logic                       PHY_Stop_Attempting_Reset,
  output logic                       busy,
  output logic      [3:0]            retry_cnt
);

  // TRANSMIT codes
  localparam logic [2:0] c_code_hard  = 3'b101;
  localparam logic [2:0] c_code_cable = 3'b110;

  // ALERT bit positions and the set of bits this block may ever drive
  localparam int          c_bit_failed    = 4;
  localparam int          c_bit_discarded = 5;
  localparam int          c_bit_success   = 6;
  localparam logic [15:0] c_alert_mask    = 16'h0070;

  // Last counter value of a WAIT_ACK attempt
  localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       c_n_retry  = 4'(N_RETRY);

  // State encoding
  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_wait_req  = 3'd1;
  localparam logic [2:0] c_st_construct = 3'd2;
  localparam logic [2:0] c_st_wait_ack  = 3'd3;
  localparam logic [2:0] c_st_success   = 3'd4;
  localparam logic [2:0] c_st_failure   = 3'd5;
  localparam logic [2:0] c_st_report    = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_state_d;

  // Registered datapath and outputs
  logic [2:0]       r_type;
  logic [4:0]       r_hi;
  logic [CNT_W-1:0] r_counter;
  logic             r_success;
  logic             r_phy_req;
  logic [2:0]       r_phy_req_type;
  logic [7:0]       r_otransmit;
  logic [15:0]      r_alert;
  logic [7:0]       r_rx_detect;
  logic [7:0]       r_rx_byte_cnt;
  logic             r_stop;
  logic             r_busy;
  logic [3:0]       r_retry_cnt;

  // Next-value wires for the datapath
  logic [2:0]       w_type_d;
  logic [4:0]       w_hi_d;
  logic [CNT_W-1:0] w_counter_d;
  logic             w_success_d;
  logic             w_phy_req_d;
  logic [2:0]       w_phy_req_type_d;
  logic [7:0]       w_otransmit_d;
  logic [15:0]      w_alert_set;
  logic [15:0]      w_alert_d;
  logic [7:0]       w_rx_detect_d;
  logic [7:0]       w_rx_byte_cnt_d;
  logic             w_stop_d;
  logic             w_busy_d;
  logic [3:0]       w_retry_cnt_d;

  // Request decode
  logic [2:0]       w_code;
  logic             w_is_hard;
  logic             w_is_cable;
  logic             w_code_ok;
  logic             w_code_rej;
  logic             w_accept;
  logic             w_discard;
  logic             w_timeout;
  logic             w_can_retry;

  assign w_code     = ioTRANSMIT[2:0];
  assign w_is_hard  = (w_code == c_code_hard);
  assign w_is_cable = (w_code == c_code_cable);

`ifdef PRL_HR_CABLE_RESET_EN
  assign w_code_ok  = w_is_hard | w_is_cable;
  assign w_code_rej = 1'b0;
`else
  // Cable reset is not supported: the code is refused and reported as discarded
  assign w_code_ok  = w_is_hard;
  assign w_code_rej = w_is_cable;
`endif

  assign w_accept    = tx_strobe & w_code_ok & (r_state == c_st_wait_req);
  assign w_discard   = tx_strobe & ((w_code_ok & r_busy) | w_code_rej);
  assign w_timeout   = (r_counter == c_tmo_last);
  assign w_can_retry = (r_retry_cnt < c_n_retry);

  // State register
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode; an ack in the timeout cycle still counts as success
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      c_st_idle:      w_state_d = c_st_wait_req;
      c_st_wait_req:  if (w_accept) w_state_d = c_st_construct;
      c_st_construct: w_state_d = c_st_wait_ack;
      c_st_wait_ack: begin
        if (phy.PHY_ACK) begin
          w_state_d = c_st_success;
        end else if (w_timeout) begin
          w_state_d = w_can_retry ? c_st_construct : c_st_failure;
        end
      end
      c_st_success:   w_state_d = c_st_report;
      c_st_failure:   w_state_d = c_st_report;
      c_st_report:    w_state_d = c_st_wait_req;
      default:        w_state_d = c_st_idle;
    endcase
  end

  // Output/datapath next values per state; everything holds unless a state updates it
  always_comb begin
    w_type_d         = r_type;
    w_hi_d           = r_hi;
    w_counter_d      = r_counter;
    w_success_d      = r_success;
    w_phy_req_d      = r_phy_req;
    w_phy_req_type_d = r_phy_req_type;
    w_otransmit_d    = r_otransmit;
    w_rx_detect_d    = r_rx_detect;
    w_rx_byte_cnt_d  = r_rx_byte_cnt;
    w_stop_d         = r_stop;
    w_retry_cnt_d    = r_retry_cnt;
    w_alert_set      = 16'h0000;

    case (r_state)
      c_st_wait_req: begin
        if (w_accept) begin
          w_type_d      = w_code;
          w_hi_d        = ioTRANSMIT[7:3];
          w_retry_cnt_d = 4'd0;
          w_stop_d      = 1'b0;
        end
      end
      c_st_construct: begin
        w_phy_req_d      = 1'b1;
        w_phy_req_type_d = r_type;
        w_counter_d      = '0;
        w_rx_detect_d    = 8'h00;
`ifdef PRL_HR_CABLE_RESET_EN
        w_rx_byte_cnt_d  = (r_type == c_code_cable) ? 8'd1 : 8'd0;
`else
        w_rx_byte_cnt_d  = 8'd0;
`endif
      end
      c_st_wait_ack: begin
        if (!phy.PHY_ACK) begin
          if (w_timeout) begin
            // Drop the request at the end of every attempt so each pulse
            // lasts exactly one timeout window
            w_phy_req_d = 1'b0;
            if (w_can_retry) begin
              w_retry_cnt_d = r_retry_cnt + 4'd1;
            end
          end else begin
            w_counter_d = r_counter + CNT_W'(1);
          end
        end
      end
      c_st_success: begin
        w_phy_req_d   = 1'b0;
        w_otransmit_d = {r_hi, r_type};
        w_success_d   = 1'b1;
      end
      c_st_failure: begin
        w_phy_req_d = 1'b0;
        w_stop_d    = 1'b1;
        w_success_d = 1'b0;
      end
      c_st_report: begin
        if (r_success) begin
          w_alert_set[c_bit_success] = 1'b1;
        end else begin
          w_alert_set[c_bit_failed] = 1'b1;
        end
      end
      default: begin
      end
    endcase

    if (w_discard) begin
      w_alert_set[c_bit_discarded] = 1'b1;
    end
  end

  // Sticky ALERT with write-1-to-clear; a set in the same cycle wins over the clear
  assign w_alert_d = ((r_alert & ~alert_clr) | w_alert_set) & c_alert_mask;
  assign w_busy_d  = (w_state_d != c_st_wait_req);

  // Datapath/output registers; reset aborts any request without reporting it
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_type         <= 3'd0;
      r_hi           <= 5'd0;
      r_counter      <= '0;
      r_success      <= 1'b0;
      r_phy_req      <= 1'b0;
      r_phy_req_type <= 3'd0;
      r_otransmit    <= 8'h00;
      r_alert        <= 16'h0000;
      r_rx_detect    <= 8'h00;
      r_rx_byte_cnt  <= 8'h00;
      r_stop         <= 1'b0;
      r_busy         <= 1'b0;
      r_retry_cnt    <= 4'd0;
    end else begin
      r_type         <= w_type_d;
      r_hi           <= w_hi_d;
      r_counter      <= w_counter_d;
      r_success      <= w_success_d;
      r_phy_req      <= w_phy_req_d;
      r_phy_req_type <= w_phy_req_type_d;
      r_otransmit    <= w_otransmit_d;
      r_alert        <= w_alert_d;
      r_rx_detect    <= w_rx_detect_d;
      r_rx_byte_cnt  <= w_rx_byte_cnt_d;
      r_stop         <= w_stop_d;
      r_busy         <= w_busy_d;
      r_retry_cnt    <= w_retry_cnt_d;
    end
  end

  assign phy.PHY_req                = r_phy_req;
  assign phy.PHY_req_type           = r_phy_req_type;
  assign oTRANSMIT                  = r_otransmit;
  assign ALERT                      = r_alert;
  assign oRECEIVE_DETECT            = r_rx_detect;
  assign oRECEIVE_BYTE_COUNT        = r_rx_byte_cnt;
  assign PHY_Stop_Attempting_Reset  = r_stop;
  assign busy                       = r_busy;
  assign retry_cnt                  = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prl_hard_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prl_hard_reset_ctrl
// Description : Scoreboard bench for prl_hard_reset_ctrl with
//               TIMEOUT_CYCLES=8, N_RETRY=1. Expected completion and discard
//               records are queued by the stimulus; a monitor pops them when
//               busy falls (completion or abort) or ALERT[5] rises (discard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prl_hard_reset_ctrl;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int CNT_W          = 16;
  localparam int N_RETRY        = 1;

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  ioTRANSMIT;
  logic        tx_strobe;
  logic [15:0] alert_clr;
  logic [7:0]  oTRANSMIT;
  logic [15:0] ALERT;
  logic [7:0]  oRECEIVE_DETECT;
  logic [7:0]  oRECEIVE_BYTE_COUNT;
  logic        PHY_Stop_Attempting_Reset;
  logic        busy;
  logic [3:0]  retry_cnt;

  prl_hard_reset_ctrl_if phy_if ();

  prl_hard_reset_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W),
    .N_RETRY        (N_RETRY)
  ) dut (
    .CLK                       (CLK),
    .reset                     (reset),
    .ioTRANSMIT                (ioTRANSMIT),
    .tx_strobe                 (tx_strobe),
    .alert_clr                 (alert_clr),
    .phy                       (phy_if),
    .oTRANSMIT                 (oTRANSMIT),
    .ALERT                     (ALERT),
    .oRECEIVE_DETECT           (oRECEIVE_DETECT),
    .oRECEIVE_BYTE_COUNT       (oRECEIVE_BYTE_COUNT),
    .PHY_Stop_Attempting_Reset (PHY_Stop_Attempting_Reset),
    .busy                      (busy),
    .retry_cnt                 (retry_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] alert;
    logic [7:0]  otx;
    logic [7:0]  rbc;
    logic        stop;
    logic [3:0]  retry;
    logic [2:0]  rtype;
    int          rises;
    int          cycles;
  } compl_t;

  typedef struct {
    logic [15:0] alert;
    logic        busy;
  } disc_t;

  compl_t cq[$];
  disc_t  dq[$];
  compl_t ce;
  disc_t  de;

  int   checks = 0;
  int   errors = 0;
  int   ack_delay = -1;
  logic mon_en = 1'b0;
  int   req_rises = 0;
  int   req_cycles = 0;
  logic prev_req = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_a5 = 1'b0;
  logic [7:0] exp_otx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_strobe(input logic [7:0] v);
    ioTRANSMIT = v;
    tx_strobe  = 1'b1;
    tick();
    tx_strobe  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
    end
    tick();
  endtask

  task automatic clear_alerts();
    alert_clr = 16'hFFFF;
    tick();
    alert_clr = 16'h0000;
  endtask

  task automatic push_cpl(input logic [15:0] a, input logic [7:0] o, input logic [7:0] b,
                          input logic s, input logic [3:0] r, input logic [2:0] t,
                          input int rs, input int cy);
    compl_t c;
    c.alert = a; c.otx = o; c.rbc = b; c.stop = s;
    c.retry = r; c.rtype = t; c.rises = rs; c.cycles = cy;
    cq.push_back(c);
  endtask

  task automatic push_disc(input logic [15:0] a, input logic b);
    disc_t d;
    d.alert = a; d.busy = b;
    dq.push_back(d);
  endtask

  // PHY model: acknowledges ack_delay cycles into each request pulse (never if negative)
  initial begin
    int age;
    age = 0;
    phy_if.PHY_ACK = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (phy_if.PHY_req && ack_delay >= 0) begin
        phy_if.PHY_ACK = (age == ack_delay);
        age++;
      end else begin
        phy_if.PHY_ACK = 1'b0;
        age = 0;
      end
    end
  end

  // Monitor: counts request pulses and checks completion / discard events
  always @(negedge CLK) begin
    if (mon_en) begin
      if (phy_if.PHY_req) req_cycles++;
      if (phy_if.PHY_req && !prev_req) req_rises++;
      if (prev_busy && !busy) begin
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion actual=busy_fall expected=none");
        end else begin
          ce = cq.pop_front();
          check("cpl_alert", 32'(ALERT), 32'(ce.alert));
          check("cpl_otransmit", 32'(oTRANSMIT), 32'(ce.otx));
          check("cpl_rx_byte_count", 32'(oRECEIVE_BYTE_COUNT), 32'(ce.rbc));
          check("cpl_rx_detect", 32'(oRECEIVE_DETECT), 32'h0);
          check("cpl_stop", 32'(PHY_Stop_Attempting_Reset), 32'(ce.stop));
          check("cpl_retry_cnt", 32'(retry_cnt), 32'(ce.retry));
          check("cpl_req_type", 32'(phy_if.PHY_req_type), 32'(ce.rtype));
          check("cpl_req_pulses", 32'(req_rises), 32'(ce.rises));
          check("cpl_req_cycles", 32'(req_cycles), 32'(ce.cycles));
        end
        req_rises  = 0;
        req_cycles = 0;
      end
      if (ALERT[5] && !prev_a5) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_discard actual=alert5 expected=none");
        end else begin
          de = dq.pop_front();
          check("disc_alert", 32'(ALERT), 32'(de.alert));
          check("disc_busy", 32'(busy), 32'(de.busy));
        end
      end
    end
    prev_req  = phy_if.PHY_req;
    prev_busy = busy;
    prev_a5   = ALERT[5];
  end

  initial begin
    int n;
    reset      = 1'b0;
    tx_strobe  = 1'b0;
    ioTRANSMIT = 8'h00;
    alert_clr  = 16'h0000;
    repeat (3) tick();

    // Reset state
    check("rst_alert", 32'(ALERT), 32'h0);
    check("rst_phy_req", 32'(phy_if.PHY_req), 32'h0);
    check("rst_req_type", 32'(phy_if.PHY_req_type), 32'h0);
    check("rst_otransmit", 32'(oTRANSMIT), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stop", 32'(PHY_Stop_Attempting_Reset), 32'h0);
    check("rst_retry_cnt", 32'(retry_cnt), 32'h0);

    reset  = 1'b1;
    mon_en = 1'b1;
    tick();
    tick();

    // Hard reset, ack in first request cycle
    ack_delay = 0;
    push_cpl(16'h0040, 8'hA5, 8'd0, 1'b0, 4'd0, 3'b101, 1, 2);
    do_strobe(8'hA5);
    wait_idle();
    exp_otx = 8'hA5;

`ifdef PRL_HR_CABLE_RESET_EN
    // Cable reset, ack in 4th request cycle
    clear_alerts();
    ack_delay = 3;
    push_cpl(16'h0040, 8'h06, 8'd1, 1'b0, 4'd0, 3'b110, 1, 5);
    do_strobe(8'h06);
    wait_idle();
    exp_otx = 8'h06;
`else
    // Cable reset code refused: discarded, no request started
    clear_alerts();
    ack_delay = 0;
    push_disc(16'h0020, 1'b0);
    do_strobe(8'h06);
    repeat (15) tick();
    check("rej110_busy", 32'(busy), 32'h0);
`endif

    // No ack: two 8-cycle pulses, then failure
    clear_alerts();
    ack_delay = -1;
    push_cpl(16'h0010, exp_otx, 8'd0, 1'b1, 4'd1, 3'b101, 2, 16);
    do_strobe(8'h05);
    wait_idle();

    // Ack coincident with the last cycle of the first attempt
    clear_alerts();
    ack_delay = 7;
    push_cpl(16'h0040, 8'h0D, 8'd0, 1'b0, 4'd0, 3'b101, 1, 9);
    do_strobe(8'h0D);
    wait_idle();

    // Strobe while busy is discarded, first request still succeeds
    clear_alerts();
    ack_delay = 2;
    push_disc(16'h0020, 1'b1);
    push_cpl(16'h0060, 8'hFD, 8'd0, 1'b0, 4'd0, 3'b101, 1, 4);
    do_strobe(8'hFD);
    do_strobe(8'h05);
    wait_idle();

    // Clear of bits 5/6 in the REPORT cycle: bit 6 set wins
    ack_delay = 0;
    push_cpl(16'h0040, 8'h1D, 8'd0, 1'b0, 4'd0, 3'b101, 1, 2);
    do_strobe(8'h1D);
    tick();
    tick();
    tick();
    alert_clr = 16'h0060;
    tick();
    alert_clr = 16'h0000;
    wait_idle();

    // Reset during WAIT_ACK aborts with everything zeroed
    ack_delay = -1;
    push_cpl(16'h0000, 8'h00, 8'd0, 1'b0, 4'd0, 3'b000, 1, 3);
    do_strobe(8'h05);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("abort_phy_req", 32'(phy_if.PHY_req), 32'h0);

    // Normal request after the abort
    ack_delay = 0;
    push_cpl(16'h0040, 8'hA5, 8'd0, 1'b0, 4'd0, 3'b101, 1, 2);
    do_strobe(8'hA5);
    wait_idle();

    n = 0;
    while ((cq.size() != 0 || dq.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    if (cq.size() != 0 || dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_expectations actual=%0d expected=0", cq.size() + dq.size());
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
